// File: rtl/relu_maxpool_2x2_pkg.sv
// relu_maxpool_2x2 shared types and helpers.
// Sample width, default map size and a signed max.
package relu_maxpool_2x2_pkg;

  localparam int DW_DEF   = 16;
  localparam int FMAP_DEF = 32;
  localparam int POOL_DEF = FMAP_DEF / 2;

  typedef logic signed [DW_DEF-1:0] sample_t;

  function automatic sample_t smax(
    input sample_t a,
    input sample_t b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relu_maxpool_2x2_if.sv
// relu_maxpool_2x2 stream interface.
// Conv result stream in, pooled stream out.
interface relu_maxpool_2x2_if #(
  parameter int DW = relu_maxpool_2x2_pkg::DW_DEF
);

  logic                 in_valid;
  logic signed [DW-1:0] data_in;
  logic                 out_valid;
  logic signed [DW-1:0] data_out;
  logic                 frame_done;

  modport master (
    output in_valid,
    output data_in,
    input  out_valid,
    input  data_out,
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  data_in,
    output out_valid,
    output data_out,
    output frame_done
  );

endinterface

// File: rtl/relu_maxpool_2x2_pool_row_buffer.sv
// Half-row store of horizontal pair maxima.
// One comb-addressed read port, one sync write port.
module pool_row_buffer
  import relu_maxpool_2x2_pkg::*;
#(
  parameter int DEPTH = POOL_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic signed [DW-1:0] wdata_i,
  output logic signed [DW-1:0] rdata_o
);

  logic signed [DW-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Contents need no reset: every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/relu_maxpool_2x2.sv
// ReLU + 2x2 stride-2 max-pool on the conv result stream.
// Even rows fill the half-row buffer, odd rows emit.
module relu_maxpool_2x2
  import relu_maxpool_2x2_pkg::*;
#(
  parameter int double_word_length = DW_DEF,
  parameter int fmap_size          = FMAP_DEF,
  parameter int cnt_length         = 8
) (
  input  logic                clk,
  input  logic                rst,
  relu_maxpool_2x2_if.slave   bus
);

  localparam int HALF = fmap_size / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [cnt_length-1:0] LAST =
    cnt_length'(fmap_size - 1);

  logic [cnt_length-1:0] row_q, row_d;
  logic [cnt_length-1:0] col_q, col_d;
  logic [cnt_length-1:0] col_half;
  logic [AW-1:0]         addr;

  sample_t pair_q;
  sample_t data_out_q;
  sample_t hmax;
  sample_t vmax;
  sample_t buf_rd;

  logic out_valid_q;
  logic frame_done_q;
  logic wr_en;
  logic emit;
  logic last_col;
  logic last_row;

  pool_row_buffer #(
    .DEPTH (HALF),
    .DW    (double_word_length),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (wr_en),
    .addr_i  (addr),
    .wdata_i (hmax),
    .rdata_o (buf_rd)
  );

  // Position decode, pair/column maxima and counter next-state.
  always_comb begin
    last_col = (col_q == LAST);
    last_row = (row_q == LAST);
    col_half = col_q >> 1;
    addr     = col_half[AW-1:0];
    hmax     = smax(pair_q, bus.data_in);
    vmax     = smax(buf_rd, hmax);
    wr_en    = bus.in_valid & ~row_q[0] & col_q[0];
    emit     = bus.in_valid & row_q[0] & col_q[0];
    col_d    = col_q;
    row_d    = row_q;
    if (bus.in_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Counters, pair latch and registered pooled output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q        <= '0;
      col_q        <= '0;
      pair_q       <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      out_valid_q  <= emit;
      frame_done_q <= emit & last_row & last_col;
      if (bus.in_valid & ~col_q[0]) begin
        pair_q <= bus.data_in;
      end
      if (emit) begin
        data_out_q <= vmax[double_word_length-1] ? '0 : vmax;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.data_out   = data_out_q;
  assign bus.frame_done = frame_done_q;

endmodule
